bcd_field_editor: RTL and testbench

BCD_FIELD_EDITOR -- requirements
Module: bcd_field_editor

---
 rtl/bcd_field_pkg.sv | 55 +++++
 rtl/bcd_tick_gen.sv | 22 ++
 rtl/bcd_field_editor.sv | 172 +++++++++++++++++
 tb/tb_bcd_field_editor.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_field_pkg.sv
// Shared definitions for the BCD field editor.
// - Field code constants (0 = idle, 10..15 are folded to idle by fld_norm).
// - Editor FSM state type.
// - Min/max BCD table per field (two digits; wider values carry zero upper digits).
// - Two-digit BCD increment/decrement helpers.
package bcd_field_pkg;

   localparam logic [3:0] FLD_IDLE  = 4'd0;
   localparam logic [3:0] FLD_SEC   = 4'd1;
   localparam logic [3:0] FLD_MIN   = 4'd2;
   localparam logic [3:0] FLD_HOUR  = 4'd3;
   localparam logic [3:0] FLD_DAY   = 4'd4;
   localparam logic [3:0] FLD_MONTH = 4'd5;
   localparam logic [3:0] FLD_YEAR  = 4'd6;
   localparam logic [3:0] FLD_AHOUR = 4'd7;
   localparam logic [3:0] FLD_AMIN  = 4'd8;
   localparam logic [3:0] FLD_ASEC  = 4'd9;

   typedef enum logic [1:0] {ST_IDLE, ST_FIRST, ST_HOLD, ST_REPEAT} edit_st_e;

   function automatic logic [3:0] fld_norm(input logic [3:0] f);
      return (f > FLD_ASEC) ? FLD_IDLE : f;
   endfunction

   function automatic logic [7:0] fld_min(input logic [3:0] f);
      case (f)
         FLD_DAY, FLD_MONTH: return 8'h01;
         default:            return 8'h00;
      endcase
   endfunction

   function automatic logic [7:0] fld_max(input logic [3:0] f);
      case (f)
         FLD_SEC, FLD_MIN, FLD_AMIN, FLD_ASEC: return 8'h59;
         FLD_HOUR, FLD_AHOUR:                 return 8'h23;
         FLD_DAY:                             return 8'h31;
         FLD_MONTH:                           return 8'h12;
         FLD_YEAR:                            return 8'h99;
         default:                             return 8'h00;
      endcase
   endfunction

   // Callers never pass 99 to bcd_inc or 00 to bcd_dec: the range check
   // against the field max/min comes first.
   function automatic logic [7:0] bcd_inc(input logic [7:0] v);
      if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
      else                return {v[7:4], v[3:0] + 4'd1};
   endfunction

   function automatic logic [7:0] bcd_dec(input logic [7:0] v);
      if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
      else                return {v[7:4], v[3:0] - 4'd1};
   endfunction

endpackage

// File: rtl/bcd_tick_gen.sv
// Free-running edit-tick prescaler.
// Ports: clk_i, rst_ni (async active low), tick_o (one-cycle pulse every
// TICK_DIV cycles, first pulse TICK_DIV-1 cycles after reset release).
module bcd_tick_gen #(
   parameter int TICK_DIV = 10000000
) (
   input  logic clk_i,
   input  logic rst_ni,
   output logic tick_o
);
   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic [CW-1:0] cnt_q;

   assign tick_o = (cnt_q == CW'(TICK_DIV - 1));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)     cnt_q <= '0;
      else if (tick_o) cnt_q <= '0;
      else             cnt_q <= cnt_q + 1'b1;
   end
endmodule

// File: rtl/bcd_field_editor.sv
// BCD field editor: holds a BCD value for the selected field and edits it
// with inc/dec keys (single step, then auto-repeat on the edit tick after
// REPEAT_DLY held ticks) or a direct load.
// Ports: clk_i, rst_ni (async active low), field_i (0/10..15 = idle),
//   inc_i/dec_i (debounced levels), load_i/load_val_i (load request),
//   value_o (registered BCD), step_o (step applied), at_min_o/at_max_o,
//   err_o (load rejected).
// Build option: define BCD_FIELD_WRAP_EN to wrap max<->min instead of
// saturating at the field limits.
module bcd_field_editor
   import bcd_field_pkg::*;
#(
   parameter int DIGITS     = 2,
   parameter int TICK_DIV   = 10000000,
   parameter int REPEAT_DLY = 4
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic [3:0]          field_i,
   input  logic                inc_i,
   input  logic                dec_i,
   input  logic                load_i,
   input  logic [4*DIGITS-1:0] load_val_i,
   output logic [4*DIGITS-1:0] value_o,
   output logic                step_o,
   output logic                at_min_o,
   output logic                at_max_o,
   output logic                err_o
);
   localparam int VW = 4 * DIGITS;
   localparam int HW = (REPEAT_DLY > 1) ? $clog2(REPEAT_DLY) : 1;

   edit_st_e      st_q, st_n;
   logic [HW-1:0] hcnt_q, hcnt_n;
   logic          armed_q, armed_n;
   logic [3:0]    fld, fld_q;
   logic [VW-1:0] val_q, val_n, fmin, fmax, qmin, qmax;
   logic          step_q, step_n, err_q, err_n;
   logic          tick, one_key, hold_done, step_req, digits_ok, load_ok;

   bcd_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .tick_o (tick)
   );

   assign fld       = fld_norm(field_i);
   assign one_key   = inc_i ^ dec_i;   // both keys together count as none
   assign hold_done = tick && (hcnt_q == HW'(REPEAT_DLY - 1));

   always_comb begin
      fmin = '0; fmax = '0; qmin = '0; qmax = '0;
      fmin[7:0] = fld_min(fld);
      fmax[7:0] = fld_max(fld);
      qmin[7:0] = fld_min(fld_q);
      qmax[7:0] = fld_max(fld_q);
   end

   // Loads are ranged numerically on the raw BCD code; valid BCD keeps order.
   always_comb begin
      digits_ok = 1'b1;
      for (int i = 0; i < DIGITS; i++)
         if (load_val_i[4*i +: 4] > 4'd9) digits_ok = 1'b0;
   end
   assign load_ok = digits_ok && (load_val_i >= fmin) && (load_val_i <= fmax);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         st_q    <= ST_IDLE;
         hcnt_q  <= '0;
         armed_q <= 1'b0;
         fld_q   <= FLD_IDLE;
         val_q   <= '0;
         step_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         st_q    <= st_n;
         hcnt_q  <= hcnt_n;
         armed_q <= armed_n;
         fld_q   <= fld;
         val_q   <= val_n;
         step_q  <= step_n;
         err_q   <= err_n;
      end
   end

   // A press only starts an edit from IDLE once the keys have been seen
   // released (armed); a key still held across reset, a field change or a
   // load therefore never steps on its own.
   always_comb begin
      st_n     = st_q;
      hcnt_n   = hcnt_q;
      armed_n  = armed_q;
      step_req = 1'b0;
      if (!one_key) armed_n = 1'b1;
      if (fld == FLD_IDLE || load_i || fld != fld_q || !one_key) begin
         st_n   = ST_IDLE;
         hcnt_n = '0;
      end else begin
         case (st_q)
            ST_IDLE: if (armed_q) begin
               st_n    = ST_FIRST;
               armed_n = 1'b0;
            end
            ST_FIRST: begin
               step_req = 1'b1;
               st_n     = ST_HOLD;
               hcnt_n   = '0;
            end
            // The REPEAT_DLY-th held tick gives the first repeat step.
            ST_HOLD: if (hold_done) begin
               step_req = 1'b1;
               st_n     = ST_REPEAT;
            end else if (tick) begin
               hcnt_n = hcnt_q + 1'b1;
            end
            ST_REPEAT: step_req = tick;
            default:   st_n = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      val_n  = val_q;
      step_n = 1'b0;
      err_n  = 1'b0;
      if (fld == FLD_IDLE) begin
         val_n = '0;
      end else if (load_i) begin
         if (load_ok) val_n = load_val_i;
         else begin
            val_n = fmin;
            err_n = 1'b1;
         end
      end else if (fld != fld_q) begin
         val_n = fmin;
      end else if (step_req) begin
         if (inc_i) begin
            if (val_q != fmax) begin
               val_n      = '0;
               val_n[7:0] = bcd_inc(val_q[7:0]);
               step_n     = 1'b1;
            end
`ifdef BCD_FIELD_WRAP_EN
            else begin
               val_n  = fmin;
               step_n = 1'b1;
            end
`endif
         end else begin
            if (val_q != fmin) begin
               val_n      = '0;
               val_n[7:0] = bcd_dec(val_q[7:0]);
               step_n     = 1'b1;
            end
`ifdef BCD_FIELD_WRAP_EN
            else begin
               val_n  = fmax;
               step_n = 1'b1;
            end
`endif
         end
      end
   end

   assign value_o  = val_q;
   assign step_o   = step_q;
   assign err_o    = err_q;
   assign at_min_o = (fld_q != FLD_IDLE) && (val_q == qmin);
   assign at_max_o = (fld_q != FLD_IDLE) && (val_q == qmax);

endmodule

// File: tb/tb_bcd_field_editor.sv
// Bench for bcd_field_editor (TICK_DIV=4, REPEAT_DLY=2): directed scenarios
// with literal expectations, then randomized traffic, all tracked by a
// decimal reference model compared on every clock.
module tb_bcd_field_editor;
   localparam int DIGITS = 2;
   localparam int TD     = 4;
   localparam int RD     = 2;
`ifdef BCD_FIELD_WRAP_EN
   localparam bit WRAP = 1'b1;
`else
   localparam bit WRAP = 1'b0;
`endif

   logic       clk, rst_n, inc, dec, load;
   logic [3:0] field;
   logic [7:0] load_val, value_o;
   logic       step_o, at_min_o, at_max_o, err_o;

   int checks = 0;
   int errors = 0;

   bcd_field_editor #(.DIGITS(DIGITS), .TICK_DIV(TD), .REPEAT_DLY(RD)) dut (
      .clk_i(clk), .rst_ni(rst_n), .field_i(field), .inc_i(inc), .dec_i(dec),
      .load_i(load), .load_val_i(load_val), .value_o(value_o), .step_o(step_o),
      .at_min_o(at_min_o), .at_max_o(at_max_o), .err_o(err_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model (decimal value, held-run counting)
   function automatic int tmin(input int f);
      return (f == 4 || f == 5) ? 1 : 0;
   endfunction
   function automatic int tmax(input int f);
      case (f)
         1, 2, 8, 9: return 59;
         3, 7:       return 23;
         4:          return 31;
         5:          return 12;
         6:          return 99;
         default:    return 0;
      endcase
   endfunction
   function automatic logic [7:0] bcd8(input int v);
      return {4'(v / 10), 4'(v % 10)};
   endfunction

   int m_val, m_pf, m_run, m_tk, m_cyc;
   bit m_arm, m_step, m_err;

   task automatic m_reset();
      m_val = 0; m_pf = 0; m_run = 0; m_tk = 0; m_cyc = 0;
      m_arm = 0; m_step = 0; m_err = 0;
   endtask

   // m_run: consecutive cycles of an eligible single-key hold (1 = press
   // accepted, 2 = first step); m_tk: edit ticks seen after the first step.
   task automatic m_adv();
      int f, lv;
      bit one, tick, stepnow, ok;
      f = (field > 9) ? 0 : int'(field);
      one = inc ^ dec;
      tick = (m_cyc % TD) == TD - 1;
      stepnow = 0; m_step = 0; m_err = 0;
      if (f != 0 && !load && f == m_pf && one) begin
         if (m_run == 0) begin
            if (m_arm) begin m_run = 1; m_tk = 0; m_arm = 0; end
         end else begin
            m_run++;
            if (m_run == 2) stepnow = 1;
            else if (tick) begin
               m_tk++;
               if (m_tk >= RD) stepnow = 1;
            end
         end
      end else begin
         m_run = 0; m_tk = 0;
      end
      if (!one) m_arm = 1;
      if (f == 0) m_val = 0;
      else if (load) begin
         ok = (load_val[3:0] <= 9) && (load_val[7:4] <= 9);
         lv = int'(load_val[7:4]) * 10 + int'(load_val[3:0]);
         if (ok && lv >= tmin(f) && lv <= tmax(f)) m_val = lv;
         else begin m_val = tmin(f); m_err = 1; end
      end else if (f != m_pf) m_val = tmin(f);
      else if (stepnow) begin
         if (inc) begin
            if (m_val < tmax(f)) begin m_val++; m_step = 1; end
            else if (WRAP) begin m_val = tmin(f); m_step = 1; end
         end else begin
            if (m_val > tmin(f)) begin m_val--; m_step = 1; end
            else if (WRAP) begin m_val = tmax(f); m_step = 1; end
         end
      end
      m_pf = f;
      m_cyc++;
   endtask

   always @(posedge clk) begin
      if (!rst_n) m_reset();
      else m_adv();
      #1;
      chk("model_value", int'(value_o), int'(bcd8(m_val)));
      chk("model_step", int'(step_o), int'(m_step));
      chk("model_err", int'(err_o), int'(m_err));
      chk("model_at_min", int'(at_min_o), int'(m_pf != 0 && m_val == tmin(m_pf)));
      chk("model_at_max", int'(at_max_o), int'(m_pf != 0 && m_val == tmax(m_pf)));
   end

   // ---------------- stimulus helpers
   task automatic wait_val(input string name, input int exp, input int budget);
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (int'(value_o) == exp) break;
      end
      chk(name, int'(value_o), exp);
   endtask

   task automatic count_steps(input string name, input int n);
      int c = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         c += int'(step_o);
      end
      chk(name, c, 0);
   endtask

   // Called just after a negedge: asserts reset mid-cycle, checks the
   // outputs cleared without a clock edge, releases two cycles later.
   task automatic do_reset();
      #2 rst_n = 1'b0;
      #1;
      chk("rst_async_value", int'(value_o), 0);
      chk("rst_async_step", int'(step_o), 0);
      chk("rst_async_flags", int'({at_min_o, at_max_o, err_o}), 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int r;
      field = 0; inc = 0; dec = 0; load = 0; load_val = 0; rst_n = 0;
      @(negedge clk);
      chk("rst_value", int'(value_o), 0);
      chk("rst_step_err", int'({step_o, err_o}), 0);
      chk("rst_at_min_max", int'({at_min_o, at_max_o}), 0);
      @(negedge clk);
      rst_n = 1;

      // field 1: carry 09 -> 10, then hold delay and auto-repeat
      @(negedge clk); field = 1;
      @(negedge clk);
      chk("f1_min", int'(value_o), 'h00);
      chk("f1_at_min", int'(at_min_o), 1);
      load = 1; load_val = 8'h09;
      @(negedge clk); load = 0; chk("load_09", int'(value_o), 'h09); inc = 1;
      @(negedge clk); chk("press_no_step_yet", int'(value_o), 'h09);
      @(negedge clk);
      chk("first_step_10", int'(value_o), 'h10);
      chk("first_step_pulse", int'(step_o), 1);
      wait_val("hold_to_11", 'h11, 12);
      wait_val("repeat_12", 'h12, 6);
      inc = 0;
      repeat (2) @(negedge clk);

      // field 3: saturate (or wrap) at 23
      field = 3; load = 1; load_val = 8'h22;
      @(negedge clk); load = 0; chk("f3_load_22", int'(value_o), 'h22); inc = 1;
      @(negedge clk);
      @(negedge clk);
      chk("f3_step_23", int'(value_o), 'h23);
      chk("f3_at_max", int'(at_max_o), 1);
      if (WRAP) wait_val("f3_wrap_00", 'h00, 12);
      else begin
         count_steps("f3_sat_no_step", 12);
         chk("f3_sat_23", int'(value_o), 'h23);
      end
      inc = 0;
      repeat (2) @(negedge clk);

      // field 4: dec at minimum 01
      field = 4;
      @(negedge clk);
      chk("f4_min_01", int'(value_o), 'h01);
      chk("f4_at_min", int'(at_min_o), 1);
      dec = 1;
      @(negedge clk);
      @(negedge clk);
      chk("f4_dec_at_min", int'(value_o), WRAP ? 'h31 : 'h01);
      chk("f4_dec_step", int'(step_o), WRAP ? 1 : 0);
      dec = 0;
      @(negedge clk);

      // loads: out of range, bad digit, valid
      field = 5; load = 1; load_val = 8'h13;
      @(negedge clk); load = 0;
      chk("load13_f5_val", int'(value_o), 'h01);
      chk("load13_f5_err", int'(err_o), 1);
      @(negedge clk); chk("err_one_cycle", int'(err_o), 0);
      field = 6; load = 1; load_val = 8'h1A;
      @(negedge clk); load = 0;
      chk("load1A_f6_val", int'(value_o), 'h00);
      chk("load1A_f6_err", int'(err_o), 1);
      field = 1; load = 1; load_val = 8'h45;
      @(negedge clk); load = 0;
      chk("load45_f1_val", int'(value_o), 'h45);
      chk("load45_f1_err", int'(err_o), 0);

      // field change while inc held, then both keys together
      inc = 1;
      wait_val("f1_inc_46", 'h46, 4);
      field = 5;
      @(negedge clk);
      chk("fchg_min_01", int'(value_o), 'h01);
      count_steps("fchg_held_no_step", 10);
      inc = 0;
      @(negedge clk);
      inc = 1; dec = 1;
      count_steps("both_keys_no_step", 10);
      chk("both_keys_val", int'(value_o), 'h01);
      inc = 0; dec = 0;
      @(negedge clk);

      // reset during REPEAT with inc still held
      field = 6;
      @(negedge clk); inc = 1;
      wait_val("f6_repeat_03", 'h03, 20);
      @(negedge clk);
      do_reset();
      count_steps("post_rst_held_no_step", 12);
      chk("post_rst_val", int'(value_o), 'h00);
      inc = 0;
      @(negedge clk); inc = 1;
      wait_val("post_rst_repress_01", 'h01, 4);
      inc = 0;

      // randomized traffic, checked by the model
      for (int n = 0; n < 3000; n++) begin
         @(negedge clk);
         load = 0;
         if ($urandom_range(0, 299) == 0) do_reset();
         else begin
            if ($urandom_range(0, 39) == 0)
               field = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15))
                                                   : 4'($urandom_range(1, 9));
            if ($urandom_range(0, 23) == 0) begin
               r = $urandom_range(0, 9);
               inc = (r < 4) || (r == 9);
               dec = (r >= 4 && r < 7) || (r == 9);
            end
            if ($urandom_range(0, 29) == 0) begin
               load = 1;
               if ($urandom_range(0, 1) == 1) load_val = bcd8($urandom_range(0, 99));
               else load_val = 8'($urandom);
            end
         end
      end
      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
